alu_mult_div: RTL and testbench

ALU_MULT_DIV -- requirements
Module: alu_mult_div

---
 rtl/alu_mult_div.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_mult_div.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_div.sv
// ALU with independent iterative 32-cycle multiplier and divider.
// Optional macro ALU_MULT_DIV_DIVIDER_EN enables the full divider.
module alu_mult_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] ALUResult,
  input  logic            multValidIn,
  input  logic            multSign,
  output logic            multValidOut,
  output logic [XLEN-1:0] multHi,
  output logic [XLEN-1:0] multLo,
  input  logic            divValidIn,
  input  logic            divSign,
  output logic            divValidOut,
  output logic [XLEN-1:0] divHi,
  output logic [XLEN-1:0] divLo
);

  localparam int W  = XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] v,
    input logic         s
  );
    return (s && v[W-1]) ? (~v + W'(1)) : v;
  endfunction

  logic [4:0] shamt;
  assign shamt = SrcA[4:0];

  // Combinational ALU operation select.
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      5'b00000: ALUResult = SrcA & SrcB;
      5'b00001: ALUResult = SrcA | SrcB;
      5'b00010: ALUResult = SrcA + SrcB;
      5'b00011: ALUResult = SrcA ^ SrcB;
      5'b00100: ALUResult = SrcB << shamt;
      5'b00101: ALUResult = SrcB >> shamt;
      5'b00110: ALUResult = SrcA - SrcB;
      5'b00111: ALUResult = W'($signed(SrcA) < $signed(SrcB));
      5'b01000: ALUResult = $signed(SrcB) >>> shamt;
      5'b01001: ALUResult = W'(SrcA < SrcB);
      5'b01010: ALUResult = {SrcB[15:0], 16'h0};
      default:  ALUResult = '0;
    endcase
  end

  // ---------------- multiplier ----------------
  // Shift-add on magnitudes; sign is applied on entry to DONE.
  state_e          mstate_q, mstate_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  mprod_q, mprod_d;
  logic            mneg_q, mneg_d;
  logic [W-1:0]    mhi_q, mhi_d;
  logic [W-1:0]    mlo_q, mlo_d;
  logic [W:0]      madd;
  logic [2*W-1:0]  mstep;
  logic [2*W-1:0]  mres;

  // Multiplier next-state and datapath.
  always_comb begin
    mstate_d = mstate_q;
    mcnt_d   = mcnt_q;
    mcand_d  = mcand_q;
    mprod_d  = mprod_q;
    mneg_d   = mneg_q;
    mhi_d    = mhi_q;
    mlo_d    = mlo_q;
    madd     = {1'b0, mprod_q[2*W-1:W]}
             + (mprod_q[0] ? {1'b0, mcand_q} : '0);
    mstep    = {madd, mprod_q[W-1:1]};
    mres     = mneg_q ? (~mstep + (2*W)'(1)) : mstep;
    case (mstate_q)
      S_IDLE: begin
        if (multValidIn) begin
          mstate_d = S_BUSY;
          mcnt_d   = '0;
          mcand_d  = mag(SrcA, multSign);
          mprod_d  = {{W{1'b0}}, mag(SrcB, multSign)};
          mneg_d   = multSign & (SrcA[W-1] ^ SrcB[W-1]);
        end
      end
      S_BUSY: begin
        mprod_d = mstep;
        mcnt_d  = mcnt_q + CW'(1);
        if (mcnt_q == LAST) begin
          mstate_d       = S_DONE;
          {mhi_d, mlo_d} = mres;
        end
      end
      S_DONE:  mstate_d = S_IDLE;
      default: mstate_d = S_IDLE;
    endcase
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstate_q <= S_IDLE;
      mcnt_q   <= '0;
      mcand_q  <= '0;
      mprod_q  <= '0;
      mneg_q   <= 1'b0;
      mhi_q    <= '0;
      mlo_q    <= '0;
    end else begin
      mstate_q <= mstate_d;
      mcnt_q   <= mcnt_d;
      mcand_q  <= mcand_d;
      mprod_q  <= mprod_d;
      mneg_q   <= mneg_d;
      mhi_q    <= mhi_d;
      mlo_q    <= mlo_d;
    end
  end

  assign multValidOut = (mstate_q == S_DONE);
  assign multHi       = mhi_q;
  assign multLo       = mlo_q;

  // ---------------- divider ----------------
  state_e dstate_q, dstate_d;
  assign divValidOut = (dstate_q == S_DONE);

`ifdef ALU_MULT_DIV_DIVIDER_EN
  // Restoring division on magnitudes. A zero divisor naturally
  // yields an all-ones quotient and the dividend as remainder,
  // so the quotient is never negated in that case.
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [W-1:0]  dq_q, dq_d;
  logic [W-1:0]  dr_q, dr_d;
  logic [W-1:0]  dd_q, dd_d;
  logic          dqneg_q, dqneg_d;
  logic          drneg_q, drneg_d;
  logic [W-1:0]  dhi_q, dhi_d;
  logic [W-1:0]  dlo_q, dlo_d;
  logic [W:0]    dsh;
  logic [W:0]    ddiff;
  logic          dge;
  logic [W-1:0]  drn;
  logic [W-1:0]  dqn;

  // Divider next-state and datapath.
  always_comb begin
    dstate_d = dstate_q;
    dcnt_d   = dcnt_q;
    dq_d     = dq_q;
    dr_d     = dr_q;
    dd_d     = dd_q;
    dqneg_d  = dqneg_q;
    drneg_d  = drneg_q;
    dhi_d    = dhi_q;
    dlo_d    = dlo_q;
    dsh      = {dr_q, dq_q[W-1]};
    ddiff    = dsh - {1'b0, dd_q};
    dge      = ~ddiff[W];
    drn      = dge ? ddiff[W-1:0] : dsh[W-1:0];
    dqn      = {dq_q[W-2:0], dge};
    case (dstate_q)
      S_IDLE: begin
        if (divValidIn) begin
          dstate_d = S_BUSY;
          dcnt_d   = '0;
          dq_d     = mag(SrcA, divSign);
          dr_d     = '0;
          dd_d     = mag(SrcB, divSign);
          dqneg_d  = divSign & (SrcA[W-1] ^ SrcB[W-1])
                   & (|SrcB);
          drneg_d  = divSign & SrcA[W-1];
        end
      end
      S_BUSY: begin
        dq_d   = dqn;
        dr_d   = drn;
        dcnt_d = dcnt_q + CW'(1);
        if (dcnt_q == LAST) begin
          dstate_d = S_DONE;
          dlo_d    = dqneg_q ? (~dqn + W'(1)) : dqn;
          dhi_d    = drneg_q ? (~drn + W'(1)) : drn;
        end
      end
      S_DONE:  dstate_d = S_IDLE;
      default: dstate_d = S_IDLE;
    endcase
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate_q <= S_IDLE;
      dcnt_q   <= '0;
      dq_q     <= '0;
      dr_q     <= '0;
      dd_q     <= '0;
      dqneg_q  <= 1'b0;
      drneg_q  <= 1'b0;
      dhi_q    <= '0;
      dlo_q    <= '0;
    end else begin
      dstate_q <= dstate_d;
      dcnt_q   <= dcnt_d;
      dq_q     <= dq_d;
      dr_q     <= dr_d;
      dd_q     <= dd_d;
      dqneg_q  <= dqneg_d;
      drneg_q  <= drneg_d;
      dhi_q    <= dhi_d;
      dlo_q    <= dlo_d;
    end
  end

  assign divHi = dhi_q;
  assign divLo = dlo_q;
`else
  // Without a divider, acknowledge a request one cycle later.
  logic div_unused;
  assign div_unused = divSign;

  // Stub handshake next-state.
  always_comb begin
    dstate_d = S_IDLE;
    if (dstate_q == S_IDLE && divValidIn) dstate_d = S_DONE;
  end

  // Stub handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dstate_q <= S_IDLE;
    else       dstate_q <= dstate_d;
  end

  assign divHi = '0;
  assign divLo = '0;
`endif

endmodule

// File: tb/tb_alu_mult_div.sv
// Directed self-checking bench for alu_mult_div.
// Divider expectations follow ALU_MULT_DIV_DIVIDER_EN.
module tb_alu_mult_div;

  logic        clk;
  logic        reset;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic        multValidIn, multSign, multValidOut;
  logic [31:0] multHi, multLo;
  logic        divValidIn, divSign, divValidOut;
  logic [31:0] divHi, divLo;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_MULT_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  alu_mult_div #(.XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .ALUResult(ALUResult),
    .multValidIn(multValidIn),
    .multSign(multSign),
    .multValidOut(multValidOut),
    .multHi(multHi),
    .multLo(multLo),
    .divValidIn(divValidIn),
    .divSign(divSign),
    .divValidOut(divValidOut),
    .divHi(divHi),
    .divLo(divLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu(
    input string       tag,
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp
  );
    @(negedge clk);
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    #1 chk(tag, 64'(ALUResult), 64'(exp));
  endtask

  // Start a multiply, scramble operands after the start edge,
  // and return the edge count at which ValidOut is seen.
  task automatic run_mult(
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat
  );
    @(negedge clk);
    multSign = s;
    SrcA = a;
    SrcB = b;
    multValidIn = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        SrcA = 32'h1234_5678;
        SrcB = 32'hDEAD_BEEF;
        multSign = ~s;
      end
      if (multValidOut) break;
    end
    multValidIn = 1'b0;
  endtask

  task automatic run_div(
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat
  );
    @(negedge clk);
    divSign = s;
    SrcA = a;
    SrcB = b;
    divValidIn = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        SrcA = 32'h0BAD_F00D;
        SrcB = 32'h0000_0003;
        divSign = ~s;
      end
      if (divValidOut) break;
    end
    divValidIn = 1'b0;
  endtask

  task automatic mult_case(
    input string       tag,
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] exp
  );
    int lat;
    run_mult(s, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_prod"}, {multHi, multLo}, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(multValidOut), 64'd0);
    chk({tag, "_hold"}, {multHi, multLo}, exp);
  endtask

  task automatic div_case(
    input string       tag,
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] q,
    input logic [31:0] r
  );
    int lat;
    run_div(s, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), DIV_EN ? 64'd33 : 64'd1);
    chk({tag, "_res"}, {divHi, divLo},
        DIV_EN ? {r, q} : 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(divValidOut), 64'd0);
  endtask

  int lat, dlat, hits;

  initial begin
    reset = 1'b1;
    ALUControl = 5'd0;
    SrcA = '0;
    SrcB = '0;
    multValidIn = 1'b0;
    multSign = 1'b0;
    divValidIn = 1'b0;
    divSign = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mvo", 64'(multValidOut), 64'd0);
    chk("rst_mprod", {multHi, multLo}, 64'd0);
    chk("rst_dvo", 64'(divValidOut), 64'd0);
    chk("rst_dres", {divHi, divLo}, 64'd0);
    reset = 1'b0;

    alu("and",  5'b00000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    alu("or",   5'b00001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001);
    alu("add",  5'b00010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu("xor",  5'b00011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu("sll",  5'b00100, 32'h0000_0024, 32'h0000_0003, 32'h0000_0030);
    alu("sub",  5'b00110, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu("slt",  5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", 5'b01001, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("sra",  5'b01000, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu("srl",  5'b00101, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu("lui",  5'b01010, 32'd0, 32'h1234_ABCD, 32'hABCD_0000);
    alu("op1f", 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    alu("op0b", 5'b01011, 32'h1234_5678, 32'h1, 32'd0);

    mult_case("mul_s", 1'b1, 32'hFFFF_FFFD, 32'd5,
              64'hFFFF_FFFF_FFFF_FFF1);
    mult_case("mul_u", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001);
    mult_case("mul_ss", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA,
              64'd42);

    div_case("div_s",  1'b1, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_case("div_u",  1'b0, 32'd7, 32'd2, 32'd3, 32'd1);
    div_case("div_z",  1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
    div_case("div_ov", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 32'd0);
    div_case("div_sz", 1'b1, 32'hFFFF_FFFB, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Concurrent mult and div; ALU stays combinational meanwhile.
    @(negedge clk);
    ALUControl = 5'b00010;
    SrcA = 32'd100;
    SrcB = 32'd7;
    multSign = 1'b0;
    divSign = 1'b0;
    multValidIn = 1'b1;
    divValidIn = 1'b1;
    lat = 0;
    dlat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 10) chk("cc_alu", 64'(ALUResult), 64'd107);
      if (divValidOut && dlat == 0) begin
        dlat = lat;
        divValidIn = 1'b0;
      end
      if (multValidOut) break;
    end
    multValidIn = 1'b0;
    divValidIn = 1'b0;
    chk("cc_mlat", 64'(lat), 64'd33);
    chk("cc_dlat", 64'(dlat), DIV_EN ? 64'd33 : 64'd1);
    chk("cc_mprod", {multHi, multLo}, 64'd700);
    chk("cc_dres", {divHi, divLo},
        DIV_EN ? {32'd2, 32'd14} : 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    multSign = 1'b1;
    SrcA = 32'd3;
    SrcB = 32'd4;
    multValidIn = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_vo", 64'(multValidOut), 64'd0);
    chk("mr_prod", {multHi, multLo}, 64'd0);
    chk("mr_dres", {divHi, divLo}, 64'd0);
    multValidIn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (multValidOut) hits++;
    end
    chk("mr_quiet", 64'(hits), 64'd0);
    chk("mr_prod2", {multHi, multLo}, 64'd0);
    mult_case("mul_rst", 1'b0, 32'd6, 32'd7, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
